rr_arb4_stream: RTL and testbench
=================================

Name: rr_arb4_stream

Overview:
- Four-input round-robin arbiter with a registered output stage. It selects one of four valid/ready producer streams and forwards its data through a single pipeline register.
- Sits directly upstream of the 4:1 datapath consumer. It also exports the registered 2-bit source index sel_o, which downstream 4:1 multiplexers use as their select.
- Guarantees fair, starvation-free access and full throughput of one transfer per cycle.

Parameters:
Width, 32, data width of every input stream and of out_o

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
in1_i  input  Width  data of stream 0
in2_i  input  Width  data of stream 1
in3_i  input  Width  data of stream 2
in4_i  input  Width  data of stream 3
valid_i  input  4  per-stream valid; bit k belongs to stream k
ready_o  output  4  per-stream ready; at most one bit high per cycle
out_o  output  Width  registered output data
out_valid_o  output  1  out_o holds an unconsumed word
out_ready_i  input  1  downstream accepts out_o this cycle
sel_o  output  2  index (0..3) of the stream that produced the current out_o

Behaviour:
- Reset is asynchronous, asserted on rst_ni=0 and independent of clk_i. While reset is asserted:
  - out_valid_o=0, out_o=0, sel_o=0.
  - Internal priority pointer ptr=0; ready_o=0.
- Load enable: load_en = ~out_valid_o | out_ready_i. The output register can accept a word whenever it is empty or is being drained in the same cycle.
- Arbitration (combinational):
  - When load_en=1, scan valid_i starting at index ptr, in order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set bit is the winner k.
  - ready_o = one-hot(k) if load_en and any valid_i bit is set; otherwise ready_o=0.
- Transfer on a rising edge when valid_i[k] & ready_o[k]:
  - out_o <= data of stream k.
  - sel_o <= k.
  - out_valid_o <= 1.
  - ptr <= (k+1) mod 4 (2-bit wrap; after k=3, ptr=0).
- Drain without refill: if out_valid_o & out_ready_i and no input transfer occurs, then out_valid_o <= 0. out_o and sel_o hold their last values.
- Stall: if out_valid_o=1 and out_ready_i=0, then ready_o=0, and out_o, sel_o, out_valid_o and ptr all hold.
- Simultaneous drain and refill (out_ready_i=1 and an input transfer in the same cycle): the new word replaces the old one, out_valid_o stays 1, and there is no bubble.
- Latency: 1 cycle from input handshake to out_valid_o. Sustained throughput is 1 word per cycle.
- ptr changes only on a completed input transfer. No-request cycles and stalled cycles leave it unchanged.
- Fairness: with all four valid bits held high, the grant sequence from reset is 0,1,2,3,0,... Any continuously requesting stream is served within 4 output transfers.
- Protocol:
  - Producers keep valid_i[k] and their data stable until ready_o[k] is seen; this is an upstream obligation.
  - The block never drops or duplicates a word.
  - ready_o depends combinationally on valid_i, out_valid_o and out_ready_i. It does not depend on data.
- Reset mid-operation: any held out_o word is discarded, out_valid_o=0 immediately (asynchronously), and ptr=0. The first grant after reset release goes to the lowest-index valid stream.

Test Plan:
- Reset: drive rst_ni=0 mid-transfer with out_valid_o=1 -> out_valid_o=0, out_o=0, sel_o=0, ready_o=0 before the next edge. After release with valid_i=4'b1010 -> stream 1 is granted first.
- All streams requesting, out_ready_i=1, in1..in4 = 0xA0,0xB1,0xC2,0xD3 -> out_o is 0xA0,0xB1,0xC2,0xD3,0xA0 on consecutive cycles, sel_o=0,1,2,3,0, out_valid_o continuously 1.
- Backpressure: out_valid_o=1, hold out_ready_i=0 for 3 cycles with valid_i=4'b1111 -> ready_o=0, and out_o/sel_o unchanged for 3 cycles. When out_ready_i=1, the next stream in rotation is granted in that same cycle.
- Wrap and skip: last grant was 2, then valid_i=4'b0001 -> stream 0 is granted (ptr wraps past 3), and ptr becomes 1.
- Single stream: only valid_i[2] held with 5 distinct words, out_ready_i=1 -> 5 consecutive transfers, sel_o=2 throughout, no bubbles.
- Drain: one word loaded, then valid_i=0 and out_ready_i=1 -> out_valid_o falls after one cycle, and out_o retains the last word.

Source files
------------

// File: rtl/rr_arb4_stream.sv
// Four-input round-robin arbiter feeding a single registered output stage.
// The registered sel_o doubles as the select for downstream 4:1 muxes.
module rr_arb4_stream #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] in1_i,
    input  logic [Width-1:0] in2_i,
    input  logic [Width-1:0] in3_i,
    input  logic [Width-1:0] in4_i,
    input  logic [3:0]       valid_i,
    output logic [3:0]       ready_o,
    output logic [Width-1:0] out_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       sel_o
);

    logic [Width-1:0] outData_q, outData_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             outValid_q, outValid_d;

    logic             loadEn;
    logic             anyValid;
    logic             xferEn;
    logic [1:0]       winner;
    logic [1:0]       scanIdx;
    logic [3:0]       grant;
    logic [Width-1:0] winData;

    assign loadEn = ~outValid_q | out_ready_i;

    // Scan from the farthest offset down so the entry nearest ptr wins.
    always_comb begin
        winner   = ptr_q;
        anyValid = 1'b0;
        scanIdx  = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            scanIdx = ptr_q + 2'(i);
            if (valid_i[scanIdx]) begin
                winner   = scanIdx;
                anyValid = 1'b1;
            end
        end
    end

    // Gated by rst_ni so no handshake is offered while reset is held.
    assign grant   = (loadEn && anyValid && rst_ni) ? (4'b0001 << winner) : 4'b0000;
    assign xferEn  = |grant;
    assign ready_o = grant;

    always_comb begin
        case (winner)
            2'd0:    winData = in1_i;
            2'd1:    winData = in2_i;
            2'd2:    winData = in3_i;
            default: winData = in4_i;
        endcase
    end

    always_comb begin
        outData_d  = outData_q;
        sel_d      = sel_q;
        outValid_d = outValid_q;
        ptr_d      = ptr_q;
        if (xferEn) begin
            outData_d  = winData;
            sel_d      = winner;
            outValid_d = 1'b1;
            ptr_d      = winner + 2'd1;
        end else if (out_ready_i) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outData_q  <= '0;
            sel_q      <= 2'd0;
            outValid_q <= 1'b0;
            ptr_q      <= 2'd0;
        end else begin
            outData_q  <= outData_d;
            sel_q      <= sel_d;
            outValid_q <= outValid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_o       = outData_q;
    assign sel_o       = sel_q;
    assign out_valid_o = outValid_q;

endmodule

// File: tb/tb_rr_arb4_stream.sv
// Self-checking bench for rr_arb4_stream: directed scenarios with literal
// expectations, then random traffic checked every cycle against a queue-free model.
module tb_rr_arb4_stream;

    logic        clk;
    logic        rst_ni;
    logic [31:0] inData [4];
    logic [3:0]  validIn;
    logic [3:0]  readyOut;
    logic [31:0] outData;
    logic        outValid;
    logic        outReady;
    logic [1:0]  selOut;

    int checks = 0;
    int errors = 0;

    rr_arb4_stream #(.Width(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in1_i       (inData[0]),
        .in2_i       (inData[1]),
        .in3_i       (inData[2]),
        .in4_i       (inData[3]),
        .valid_i     (validIn),
        .ready_o     (readyOut),
        .out_o       (outData),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .sel_o       (selOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic r,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] d3);
        @(posedge clk);
        #1;
        validIn   = v;
        outReady  = r;
        inData[0] = d0;
        inData[1] = d1;
        inData[2] = d2;
        inData[3] = d3;
    endtask

    task automatic expectState(input string tag, input logic [31:0] eOut, input logic [1:0] eSel,
                               input logic eValid, input logic [3:0] eReady);
        #1;
        checkOutput({tag, ".out"},   outData,         eOut);
        checkOutput({tag, ".sel"},   32'(selOut),     32'(eSel));
        checkOutput({tag, ".valid"}, 32'(outValid),   32'(eValid));
        checkOutput({tag, ".ready"}, 32'(readyOut),   32'(eReady));
    endtask

    // Reference model: output register contents and rotation pointer as plain ints.
    int          mPtr;
    bit          mValid;
    logic [31:0] mOut;
    int          mSel;

    initial begin
        int          win;
        logic [3:0]  expReady;
        logic [31:0] winData;
        bit          canLoad;
        mPtr = 0; mValid = 0; mOut = 0; mSel = 0;
        forever begin
            @(negedge clk);
            win = -1;
            winData = 0;
            if (!rst_ni) begin
                mPtr = 0; mValid = 0; mOut = 0; mSel = 0;
                expReady = 4'b0000;
            end else begin
                canLoad = !mValid || outReady;
                if (canLoad) begin
                    for (int i = 0; i < 4; i++) begin
                        if (win < 0 && validIn[(mPtr + i) % 4]) win = (mPtr + i) % 4;
                    end
                end
                expReady = (win >= 0) ? 4'(1 << win) : 4'b0000;
                if (win >= 0) winData = inData[win];
            end
            checkOutput("model.ready", 32'(readyOut), 32'(expReady));
            checkOutput("model.valid", 32'(outValid), 32'(mValid));
            checkOutput("model.out",   outData,       mOut);
            checkOutput("model.sel",   32'(selOut),   32'(mSel));
            @(posedge clk);
            if (rst_ni) begin
                if (win >= 0) begin
                    mOut   = winData;
                    mSel   = win;
                    mValid = 1;
                    mPtr   = (win + 1) % 4;
                end else if (mValid && outReady) begin
                    mValid = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] rrOut [5];
        logic [31:0] words [6];
        rrOut = '{32'hA0, 32'hB1, 32'hC2, 32'hD3, 32'hA0};
        for (int j = 0; j < 6; j++) words[j] = 32'h2000_0000 + 32'(j) * 32'h111;

        rst_ni    = 1'b0;
        validIn   = 4'b1111;
        outReady  = 1'b1;
        inData[0] = 32'hA0; inData[1] = 32'hB1; inData[2] = 32'hC2; inData[3] = 32'hD3;
        repeat (2) @(posedge clk);
        #1;
        expectState("reset", 32'h0, 2'd0, 1'b0, 4'b0000);

        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        expectState("first", 32'h0, 2'd0, 1'b0, 4'b0001);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 1'b1, 32'hA0, 32'hB1, 32'hC2, 32'hD3);
            expectState($sformatf("rr%0d", i), rrOut[i], 2'(i % 4), 1'b1, 4'(1 << ((i + 1) % 4)));
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 1'b0, 32'hA0, 32'hB1, 32'hC2, 32'hD3);
            expectState($sformatf("stall%0d", i), 32'hB1, 2'd1, 1'b1, 4'b0000);
        end
        applyStimulus(4'b1111, 1'b1, 32'hA0, 32'hB1, 32'hC2, 32'hD3);
        expectState("unstall", 32'hB1, 2'd1, 1'b1, 4'b0100);

        applyStimulus(4'b0001, 1'b1, 32'hA0, 32'hB1, 32'hC2, 32'hD3);
        expectState("wrap", 32'hC2, 2'd2, 1'b1, 4'b0001);
        applyStimulus(4'b0011, 1'b1, 32'hA0, 32'hB1, 32'hC2, 32'hD3);
        expectState("skip", 32'hA0, 2'd0, 1'b1, 4'b0010);

        applyStimulus(4'b0100, 1'b1, 32'hA0, 32'hB1, words[0], 32'hD3);
        expectState("single0", 32'hB1, 2'd1, 1'b1, 4'b0100);
        for (int j = 1; j < 6; j++) begin
            applyStimulus(4'b0100, 1'b1, 32'hA0, 32'hB1, words[j], 32'hD3);
            expectState($sformatf("single%0d", j), words[j-1], 2'd2, 1'b1, 4'b0100);
        end

        applyStimulus(4'b0000, 1'b1, 32'hA0, 32'hB1, 32'hC2, 32'hD3);
        expectState("drain0", words[5], 2'd2, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 32'hA0, 32'hB1, 32'hC2, 32'hD3);
        expectState("drain1", words[5], 2'd2, 1'b0, 4'b0000);

        applyStimulus(4'b1000, 1'b1, 32'hA0, 32'hB1, 32'hC2, 32'hD3);
        expectState("load3", words[5], 2'd2, 1'b0, 4'b1000);
        applyStimulus(4'b1111, 1'b0, 32'hA0, 32'hB1, 32'hC2, 32'hD3);
        expectState("held3", 32'hD3, 2'd3, 1'b1, 4'b0000);
        rst_ni = 1'b0;
        expectState("midReset", 32'h0, 2'd0, 1'b0, 4'b0000);

        @(posedge clk);
        #1;
        rst_ni   = 1'b1;
        validIn  = 4'b1010;
        outReady = 1'b1;
        expectState("postReset", 32'h0, 2'd0, 1'b0, 4'b0010);
        applyStimulus(4'b1010, 1'b1, 32'hA0, 32'hB1, 32'hC2, 32'hD3);
        expectState("postReset1", 32'hB1, 2'd1, 1'b1, 4'b1000);

        // Random traffic, with occasional single-cycle resets.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
                          $urandom, $urandom, $urandom, $urandom);
            if ($urandom_range(0, 399) == 0) begin
                #1;
                rst_ni = 1'b0;
                @(posedge clk);
                #1;
                rst_ni = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
